adsr_step_calc: RTL and testbench

ADSR_STEP_CALC -- requirements
Module: adsr_step_calc

---
 rtl/adsr_step_calc_pkg.sv | 31 +++
 rtl/adsr_step_calc_div.sv | 66 ++++++
 rtl/adsr_step_calc.sv | 175 +++++++++++++++++
 tb/tb_adsr_step_calc.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/adsr_step_calc_pkg.sv
// Shared constants, env_mode encoding and FSM state type for the ADSR step calculator.
package adsr_step_calc_pkg;

  localparam logic [31:0] MAX    = 32'h8000_0000;
  localparam logic [31:0] BYPASS = 32'hFFFF_FFFF;
  localparam logic [31:0] ZERO   = 32'h0000_0000;
  localparam logic [31:0] ONE    = 32'h0000_0001;

  localparam logic [1:0] MODE_NORMAL     = 2'b00;
  localparam logic [1:0] MODE_BYPASS     = 2'b01;
  localparam logic [1:0] MODE_MUTE       = 2'b10;
  localparam logic [1:0] MODE_NORMAL_ALT = 2'b11;

  localparam int         NUM_SEG  = 3;
  localparam logic [5:0] DIV_LAST = 6'd32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DIV_A  = 3'd2,
    DIV_D  = 3'd3,
    DIV_R  = 3'd4,
    COMMIT = 3'd5
  } adsr_state_t;

  // Sustain is a Q1.31 amplitude; anything above full scale saturates to 1.0.
  function automatic logic [31:0] clamp_sustain(input logic [31:0] s);
    return (s > MAX) ? MAX : s;
  endfunction

endpackage

// File: rtl/adsr_step_calc_div.sv
// Serial restoring 32/32 unsigned divider: one quotient bit per clock, fixed 32 iterations.
module udiv32_serial
  import adsr_step_calc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        valid,
  output logic [31:0] quotient
);

  logic [31:0] rem_reg, quo_reg, dsr_reg;
  logic [5:0]  count_reg;
  logic        busy_reg, dzero_reg;

  logic [31:0] rem_src, quo_src, dsr_src;
  logic [32:0] trial;
  logic        fits;
  logic [31:0] rem_next, quo_next;

  // The issue edge already performs the first iteration, so the result is
  // ready 32 edges after go and the caller sees it in its 33rd cycle.
  always_comb begin
    rem_src  = busy_reg ? rem_reg : ZERO;
    quo_src  = busy_reg ? quo_reg : dividend;
    dsr_src  = busy_reg ? dsr_reg : divisor;
    trial    = {rem_src, quo_src[31]};
    fits     = (trial >= {1'b0, dsr_src});
    rem_next = fits ? 32'(trial - {1'b0, dsr_src}) : trial[31:0];
    quo_next = {quo_src[30:0], fits};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_reg   <= ZERO;
      quo_reg   <= ZERO;
      dsr_reg   <= ZERO;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      dzero_reg <= 1'b0;
    end else if (!busy_reg) begin
      if (go) begin
        rem_reg   <= rem_next;
        quo_reg   <= quo_next;
        dsr_reg   <= divisor;
        dzero_reg <= (divisor == ZERO);
        count_reg <= 6'd1;
        busy_reg  <= 1'b1;
      end
    end else if (count_reg == DIV_LAST) begin
      busy_reg <= 1'b0;
    end else begin
      rem_reg   <= rem_next;
      quo_reg   <= quo_next;
      count_reg <= count_reg + 6'd1;
    end
  end

  assign busy     = busy_reg;
  assign valid    = busy_reg && (count_reg == DIV_LAST);
  assign quotient = dzero_reg ? BYPASS : quo_reg;

endmodule

// File: rtl/adsr_step_calc.sv
// Converts ADSR segment times into per-clock Q1.31 step increments using one shared serial divider.
module adsr_step_calc
  import adsr_step_calc_pkg::*;
#(
  parameter int CLKS_PER_MS = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [14:0] attack_ms,
  input  logic [14:0] decay_ms,
  input  logic [14:0] release_ms,
  input  logic [31:0] sustain_in,
  input  logic [1:0]  env_mode,
  output logic [31:0] attack_step_value,
  output logic [31:0] decay_step_value,
  output logic [31:0] release_step_value,
  output logic [31:0] sustain_level,
  output logic        ready,
  output logic        done
);

  localparam logic [31:0] CLKS_U = 32'(CLKS_PER_MS);

  adsr_state_t state_reg, state_next;

  logic [14:0] ms_in       [NUM_SEG];
  logic [14:0] ms_reg      [NUM_SEG];
  logic [31:0] cycles_reg  [NUM_SEG];
  logic [31:0] step_sh_reg [NUM_SEG];
  logic [31:0] seg_value   [NUM_SEG];
  logic [31:0] sus_in_reg, sus_reg;
  logic [1:0]  mode_reg;
  logic [5:0]  cnt_reg;

  logic        accept, in_div, div_last, capture;
  logic [1:0]  seg_sel;
  logic [31:0] num_sel, den_sel, step_result;
  logic        div_go, div_busy, div_valid;
  logic [31:0] div_quotient;

  assign ms_in[0] = attack_ms;
  assign ms_in[1] = decay_ms;
  assign ms_in[2] = release_ms;

  assign ready  = (state_reg == IDLE);
  assign accept = ready && start;

  always_comb begin
    in_div  = 1'b1;
    seg_sel = 2'd0;
    case (state_reg)
      DIV_A:   seg_sel = 2'd0;
      DIV_D:   seg_sel = 2'd1;
      DIV_R:   seg_sel = 2'd2;
      default: in_div  = 1'b0;
    endcase
  end

  always_comb begin
    case (seg_sel)
      2'd0: begin
        num_sel = MAX;
        den_sel = cycles_reg[0];
      end
      2'd1: begin
        num_sel = MAX - sus_reg;
        den_sel = cycles_reg[1];
      end
      default: begin
        num_sel = sus_reg;
        den_sel = cycles_reg[2];
      end
    endcase
  end

  // A zero-length segment skips the divider but still occupies its 33 cycles.
  assign div_last    = in_div && (cnt_reg == DIV_LAST);
  assign div_go      = in_div && (cnt_reg == 6'd0) && (den_sel != ZERO) && !div_busy;
  assign capture     = div_last && ((den_sel == ZERO) || div_valid);
  assign step_result = (den_sel == ZERO)      ? MAX :
                       (div_quotient == ZERO) ? ONE : div_quotient;

  udiv32_serial u_div (
    .clk      (clk),
    .reset    (reset),
    .go       (div_go),
    .dividend (num_sel),
    .divisor  (den_sel),
    .busy     (div_busy),
    .valid    (div_valid),
    .quotient (div_quotient)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = DIV_A;
      DIV_A:   if (div_last) state_next = DIV_D;
      DIV_D:   if (div_last) state_next = DIV_R;
      DIV_R:   if (div_last) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= (in_div && !div_last) ? cnt_reg + 6'd1 : 6'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sus_in_reg <= ZERO;
      mode_reg   <= MODE_NORMAL;
      sus_reg    <= ZERO;
    end else begin
      if (accept) begin
        sus_in_reg <= sustain_in;
        mode_reg   <= env_mode;
      end
      if (state_reg == LOAD) sus_reg <= clamp_sustain(sus_in_reg);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SEG; gi++) begin : g_seg
      if (gi == 0) begin : g_attack
        assign seg_value[gi] = (mode_reg == MODE_BYPASS) ? BYPASS :
                               (mode_reg == MODE_MUTE)   ? ZERO   : step_result;
      end else begin : g_plain
        assign seg_value[gi] = step_result;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ms_reg[gi]      <= '0;
          cycles_reg[gi]  <= ZERO;
          step_sh_reg[gi] <= MAX;
        end else begin
          if (accept) ms_reg[gi] <= ms_in[gi];
          if (state_reg == LOAD) cycles_reg[gi] <= 32'(ms_reg[gi]) * CLKS_U;
          if (capture && (seg_sel == 2'(gi))) step_sh_reg[gi] <= seg_value[gi];
        end
      end
    end
  endgenerate

  // Outputs only change in COMMIT, so an aborted run can never leak a partial result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      attack_step_value  <= BYPASS;
      decay_step_value   <= MAX;
      release_step_value <= MAX;
      sustain_level      <= MAX;
      done               <= 1'b0;
    end else if (state_reg == COMMIT) begin
      attack_step_value  <= step_sh_reg[0];
      decay_step_value   <= step_sh_reg[1];
      release_step_value <= step_sh_reg[2];
      sustain_level      <= sus_reg;
      done               <= 1'b1;
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adsr_step_calc.sv
// Directed bench for adsr_step_calc: latency, computed steps, clamps, modes and abort behaviour.
module tb_adsr_step_calc;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [14:0] attack_ms, decay_ms, release_ms;
  logic [31:0] sustain_in;
  logic [1:0]  env_mode;
  logic [31:0] attack_step_value, decay_step_value, release_step_value, sustain_level;
  logic        ready, done;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  adsr_step_calc dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .attack_ms          (attack_ms),
    .decay_ms           (decay_ms),
    .release_ms         (release_ms),
    .sustain_in         (sustain_in),
    .env_mode           (env_mode),
    .attack_step_value  (attack_step_value),
    .decay_step_value   (decay_step_value),
    .release_step_value (release_step_value),
    .sustain_level      (sustain_level),
    .ready              (ready),
    .done               (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic set_inputs(input logic [14:0] a, d, r, input logic [31:0] s, input logic [1:0] m);
    attack_ms  = a;
    decay_ms   = d;
    release_ms = r;
    sustain_in = s;
    env_mode   = m;
  endtask

  // Leaves the caller at the falling edge just after the accepting edge k.
  task automatic start_op(input logic [14:0] a, d, r, input logic [31:0] s, input logic [1:0] m);
    @(negedge clk);
    set_inputs(a, d, r, s, m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // act: 0 plain, 1 perturb inputs and retrigger mid-run, 2 reset mid-run, 3 start during COMMIT.
  task automatic wait_done(input int act, output int lat, output logic mid_ready);
    lat       = -1;
    mid_ready = 1'b1;
    for (int i = 1; i <= 150; i++) begin
      if (act == 1 && i == 2)  set_inputs(15'd1, 15'd1, 15'd1, 32'hFFFF_FFFF, 2'b01);
      if (act == 1 && i == 50) start = 1'b1;
      if (act == 1 && i == 51) start = 1'b0;
      if (act == 2 && i == 60) reset = 1'b1;
      if (act == 2 && i == 61) reset = 1'b0;
      if (act == 3 && i == 101) begin
        start = 1'b1;
        set_inputs(15'd10, 15'd20, 15'd5, 32'h0000_0000, 2'b11);
      end
      @(negedge clk);
      if (i == 50) mid_ready = ready;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_outputs(input string name, input logic [31:0] ea, ed, er, es);
    check_val({name, "_attack"},  attack_step_value,  ea);
    check_val({name, "_decay"},   decay_step_value,   ed);
    check_val({name, "_release"}, release_step_value, er);
    check_val({name, "_sustain"}, sustain_level,      es);
  endtask

  task automatic do_op(input string name, input logic [14:0] a, d, r, input logic [31:0] s,
                       input logic [1:0] m, input int act, input logic [31:0] ea, ed, er, es);
    int   lat;
    logic mid_ready;
    start_op(a, d, r, s, m);
    wait_done(act, lat, mid_ready);
    check_val({name, "_latency"}, 32'(lat), 32'd101);
    check_val({name, "_busy_ready"}, {31'd0, mid_ready}, 32'd0);
    check_outputs(name, ea, ed, er, es);
    check_val({name, "_ready"}, {31'd0, ready}, 32'd1);
    @(negedge clk);
    check_val({name, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int   lat;
    logic mid_ready;
    reset = 1'b1;
    start = 1'b0;
    set_inputs('0, '0, '0, '0, 2'b00);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs("rst", 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    check_val("rst_ready", {31'd0, ready}, 32'd1);
    check_val("rst_done",  {31'd0, done},  32'd0);

    do_op("basic",   15'd10, 15'd20, 15'd100, 32'h4000_0000, 2'b00, 0,
          32'd2147, 32'd536, 32'd107, 32'h4000_0000);
    do_op("zero_ms", 15'd0, 15'd0, 15'd0, 32'h2000_0000, 2'b00, 0,
          32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h2000_0000);
    do_op("sus_hi",  15'd10, 15'd1, 15'd100, 32'hC000_0000, 2'b00, 0,
          32'd2147, 32'd1, 32'd214, 32'h8000_0000);
    do_op("sus_zero", 15'd10, 15'd20, 15'd5, 32'h0000_0000, 2'b00, 0,
          32'd2147, 32'd1073, 32'd1, 32'h0000_0000);
    do_op("bypass",  15'd10, 15'd20, 15'd100, 32'h4000_0000, 2'b01, 0,
          32'hFFFF_FFFF, 32'd536, 32'd107, 32'h4000_0000);
    do_op("mute",    15'd10, 15'd20, 15'd100, 32'h4000_0000, 2'b10, 0,
          32'h0000_0000, 32'd536, 32'd107, 32'h4000_0000);
    do_op("perturb", 15'd5, 15'd40, 15'd200, 32'h1000_0000, 2'b00, 1,
          32'd4294, 32'd469, 32'd13, 32'h1000_0000);

    // Abort mid-run: outputs fall back to reset values and no done appears.
    start_op(15'd10, 15'd20, 15'd100, 32'h4000_0000, 2'b00);
    wait_done(2, lat, mid_ready);
    check_val("abort_no_done", 32'(lat), 32'hFFFF_FFFF);
    check_outputs("abort", 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    check_val("abort_ready", {31'd0, ready}, 32'd1);
    do_op("after_abort", 15'd10, 15'd20, 15'd100, 32'h4000_0000, 2'b00, 0,
          32'd2147, 32'd536, 32'd107, 32'h4000_0000);

    // Start held from the COMMIT cycle into the next IDLE cycle: only the latter counts.
    start_op(15'd0, 15'd0, 15'd0, 32'h2000_0000, 2'b00);
    wait_done(3, lat, mid_ready);
    check_val("commit_latency", 32'(lat), 32'd101);
    check_outputs("commit_first", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h2000_0000);
    @(negedge clk);
    start = 1'b0;
    check_val("commit_accept_ready", {31'd0, ready}, 32'd0);
    check_val("commit_done_pulse",   {31'd0, done},  32'd0);
    wait_done(0, lat, mid_ready);
    check_val("commit_second_latency", 32'(lat), 32'd101);
    check_outputs("commit_second", 32'd2147, 32'd1073, 32'd1, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
